lmsm_reg_sequencer: RTL and testbench

//  Parametrised register-list walker for the multi-register load/store (LM/SM) datapath.

---
 rtl/lmsm_pkg.sv | 22 ++
 rtl/lsb_first_encoder.sv | 40 ++++
 rtl/lmsm_reg_sequencer.sv | 141 ++++++++++++++
 tb/tb_lmsm_reg_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lmsm_pkg
//  Purpose  : Shared types and default sizing for the LM/SM register-list
//             sequencer (state encoding, default widths).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package lmsm_pkg;

  localparam int unsigned NREGS_DEFAULT  = 8;
  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam int unsigned IDX_W_DEFAULT  = $clog2(NREGS_DEFAULT);
  localparam int unsigned CNT_W_DEFAULT  = $clog2(NREGS_DEFAULT + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage : lmsm_pkg
`default_nettype wire

// File: rtl/lsb_first_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : lsb_first_encoder
//  Purpose  : Combinational priority encoder, lowest set bit wins. Also
//             reports whether any bit is set and whether exactly one is set.
//  Ports    : vec_i    [NREGS-1:0]  input vector
//             idx_o    [IDX_W-1:0]  index of lowest set bit (0 when none)
//             any_o                 at least one bit set
//             onehot_o              exactly one bit set
//  Revision : 1.0  initial release
// ============================================================================
module lsb_first_encoder
  import lmsm_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int IDX_W = $clog2(NREGS)
) (
  input  logic [NREGS-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             onehot_o
);

  // Scan from the top down so the last match (the lowest index) wins.
  always_comb begin
    idx_o = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign any_o = |vec_i;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign onehot_o = any_o && ((vec_i & (vec_i - NREGS'(1))) == '0);

endmodule : lsb_first_encoder
`default_nettype wire

// File: rtl/lmsm_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lmsm_reg_sequencer
//  Purpose  : Register-list walker for multi-register load/store. Latches a
//             register mask on start and presents one register index per
//             accepted step, lowest set bit first.
//  Config   : LMSM_ADDR_GEN_EN - when defined, mem_addr is loaded from
//             base_addr on start and incremented per accepted step;
//             otherwise mem_addr is tied to zero and base_addr is unused.
//  Ports    : clk, rst (async, active high)
//             start, mask[NREGS], abort, step, base_addr[ADDR_W]   inputs
//             busy, vld, reg_idx[IDX_W], first, last, count[CNT_W],
//             mem_addr[ADDR_W], done                               outputs
//  Revision : 1.0  initial release
// ============================================================================
module lmsm_reg_sequencer
  import lmsm_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int IDX_W  = $clog2(NREGS),
  parameter int CNT_W  = $clog2(NREGS + 1),
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NREGS-1:0]  mask,
  input  logic              abort,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              vld,
  output logic [IDX_W-1:0]  reg_idx,
  output logic              first,
  output logic              last,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              done
);

  state_t             state_q;
  logic [NREGS-1:0]   pend_q;
  logic [NREGS-1:0]   pend_d;
  logic [CNT_W-1:0]   count_q;
  logic               done_q;

  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_onehot;
  logic               w_start_acc;
  logic               w_step_acc;

  lsb_first_encoder #(
    .NREGS (NREGS),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i    (pend_q),
    .idx_o    (w_idx),
    .any_o    (w_any),
    .onehot_o (w_onehot)
  );

  // Abort outranks both start and step.
  assign w_start_acc = (state_q == IDLE) && start && !abort;
  assign w_step_acc  = (state_q == BUSY) && step  && !abort;

  // Pending set with the currently presented register removed.
  assign pend_d = pend_q & ~(NREGS'(1) << w_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_start_acc) begin
            pend_q  <= mask;
            count_q <= '0;
            // An empty list completes immediately without ever going valid.
            if (mask == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (abort) begin
            state_q <= IDLE;
            pend_q  <= '0;
          end else if (w_step_acc) begin
            pend_q  <= pend_d;
            count_q <= count_q + CNT_W'(1);
            if (w_onehot) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef LMSM_ADDR_GEN_EN
  logic [ADDR_W-1:0] addr_q;

  // Wraps modulo 2**ADDR_W; abort leaves the address where it stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (w_start_acc) begin
      addr_q <= base_addr;
    end else if (w_step_acc) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign mem_addr = addr_q;
`else
  logic w_unused_base_addr;
  assign w_unused_base_addr = ^base_addr;
  assign mem_addr           = '0;
`endif

  assign busy    = (state_q == BUSY);
  assign vld     = busy;
  assign reg_idx = w_idx;
  assign first   = busy && w_any && (count_q == '0);
  assign last    = busy && w_onehot;
  assign count   = count_q;
  assign done    = done_q;

endmodule : lmsm_reg_sequencer
`default_nettype wire

// File: tb/tb_lmsm_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lmsm_reg_sequencer
//  Purpose  : Scoreboard bench for lmsm_reg_sequencer. A list-level model
//             (queue of pending register numbers) predicts accepted
//             transfers and done pulses; a negedge monitor compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lmsm_reg_sequencer;

  localparam int NREGS  = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [NREGS-1:0]  mask = '0;
  logic              abort = 1'b0;
  logic              step = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy;
  logic              vld;
  logic [IDX_W-1:0]  reg_idx;
  logic              first;
  logic              last;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] mem_addr;
  logic              done;

  lmsm_reg_sequencer #(
    .NREGS  (NREGS),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mask      (mask),
    .abort     (abort),
    .step      (step),
    .base_addr (base_addr),
    .busy      (busy),
    .vld       (vld),
    .reg_idx   (reg_idx),
    .first     (first),
    .last      (last),
    .count     (count),
    .mem_addr  (mem_addr),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int addr;
    int cnt;
  } acc_t;

  acc_t exp_acc_q[$];
  int   exp_done_q[$];

  // Reference model: state after the most recent clock edge.
  int m_pend[$];
  bit m_busy;
  int m_count;
  int m_addr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int addr_exp(input int a);
`ifdef LMSM_ADDR_GEN_EN
    return a;
`else
    return 0 * a;
`endif
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_busy  = 1'b0;
    m_count = 0;
    m_addr  = 0;
  endtask

  // Apply one cycle of inputs (called at posedge+1), then advance the model.
  task automatic cyc(input bit s, input logic [NREGS-1:0] m, input bit st,
                     input bit ab, input logic [ADDR_W-1:0] b);
    acc_t e;
    start = s; mask = m; step = st; abort = ab; base_addr = b;
    if (m_busy && st && !ab) begin
      e.idx  = m_pend[0];
      e.addr = addr_exp(m_addr);
      e.cnt  = m_count;
      exp_acc_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (ab) begin
      if (m_busy) begin
        m_busy = 1'b0;
        m_pend.delete();
      end
    end else if (!m_busy && s) begin
      m_pend.delete();
      for (int i = 0; i < NREGS; i++) if (m[i]) m_pend.push_back(i);
      m_count = 0;
      m_addr  = int'(b);
      if (m_pend.size() == 0) exp_done_q.push_back(0);
      else                    m_busy = 1'b1;
    end else if (m_busy && st) begin
      void'(m_pend.pop_front());
      m_count++;
      m_addr = (m_addr + 1) % (1 << ADDR_W);
      if (m_pend.size() == 0) begin
        m_busy = 1'b0;
        exp_done_q.push_back(m_count);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: inputs and outputs are both settled at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      acc_t e;
      int   dc;
      chk("vld", vld, m_busy);
      chk("busy", busy, m_busy);
      if (vld && m_pend.size() > 0) begin
        chk("reg_idx", reg_idx, m_pend[0]);
        chk("first", first, m_count == 0);
        chk("last", last, m_pend.size() == 1);
      end
      if (!vld) begin
        chk("first_idle", first, 0);
        chk("last_idle", last, 0);
      end
      if (vld && step && !abort) begin
        if (exp_acc_q.size() == 0) begin
          chk("accept_unexpected", 1, 0);
        end else begin
          e = exp_acc_q.pop_front();
          chk("acc_idx", reg_idx, e.idx);
          chk("acc_addr", mem_addr, e.addr);
          chk("acc_count", count, e.cnt);
        end
      end else if (exp_acc_q.size() != 0) begin
        chk("accept_missing", 0, 1);
        exp_acc_q.delete();
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          dc = exp_done_q.pop_front();
          chk("done_count", count, dc);
        end
      end else if (exp_done_q.size() != 0) begin
        chk("done_missing", 0, 1);
        void'(exp_done_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_idx", reg_idx, 0);
    chk("rst_addr", mem_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Walk 0,2,5,7 with step held high.
    cyc(1'b1, 8'hA5, 1'b1, 1'b0, 16'h0100);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0);
    idle(2);
    chk("list1_count", count, 4);

    // Empty list: done without valid.
    cyc(1'b1, 8'h00, 1'b1, 1'b0, '0);
    idle(2);

    // Back-pressure then two steps.
    cyc(1'b1, 8'h81, 1'b0, 1'b0, 16'hFFFF);
    idle(3);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    idle(2);

    // Abort together with step at reg_idx 1, then a fresh start.
    cyc(1'b1, 8'h0F, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    cyc(1'b1, 8'h33, 1'b1, 1'b1, '0);
    chk("abort_count", count, 1);
    chk("abort_vld", vld, 0);
    idle(1);
    cyc(1'b1, 8'h0E, 1'b0, 1'b0, 16'h0040);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0);
    idle(2);

    // Asynchronous reset mid-list at reg_idx 3.
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 16'h1234);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0);
    chk("pre_rst_idx", reg_idx, 3);
    step = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vld", vld, 0);
    chk("mid_rst_idx", reg_idx, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_done", done, 0);
    model_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit               s;
      bit               st;
      bit               ab;
      logic [NREGS-1:0] m;
      s  = ($urandom_range(0, 2) == 0);
      m  = ($urandom_range(0, 5) == 0) ? '0 : NREGS'($urandom);
      st = ($urandom_range(0, 2) != 0);
      ab = ($urandom_range(0, 24) == 0);
      cyc(s, m, st, ab, ADDR_W'($urandom));
    end
    cyc(1'b0, '0, 1'b0, 1'b1, '0);
    idle(3);

    chk("acc_queue_drained", exp_acc_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lmsm_reg_sequencer
`default_nettype wire
